// File: rtl/mdio_pkg.sv
// Shared Clause-22 MDIO frame constants and responder state encoding.
package mdio_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned OP_W     = 2;
    localparam int unsigned NUM_REGS = 32;

    // Frame bit indices, counted from the first bit after the preamble.
    localparam logic [4:0] ST_POS     = 5'd0;
    localparam logic [4:0] ST_LAST    = 5'd1;
    localparam logic [4:0] OP_POS     = 5'd2;
    localparam logic [4:0] PHY_POS    = 5'd4;
    localparam logic [4:0] REG_POS    = 5'd9;
    localparam logic [4:0] HDR_LAST   = 5'd13;
    localparam logic [4:0] TA_POS     = 5'd14;
    localparam logic [4:0] TA_LAST    = 5'd15;
    localparam logic [4:0] DATA_POS   = 5'd16;
    localparam logic [4:0] FRAME_LAST = 5'd31;

    localparam logic [OP_W-1:0] OP_READ  = 2'b10;
    localparam logic [OP_W-1:0] OP_WRITE = 2'b01;
    localparam logic [1:0]      ST_CODE  = 2'b01;
    localparam logic [1:0]      TA_WR    = 2'b10;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HDR   = 3'd1;
    localparam logic [2:0] RTA   = 3'd2;
    localparam logic [2:0] RDATA = 3'd3;
    localparam logic [2:0] WTA   = 3'd4;
    localparam logic [2:0] WDATA = 3'd5;
    localparam logic [2:0] SKIP  = 3'd6;

endpackage

// File: rtl/mdio_regfile.sv
// 32 x 16 register file: one synchronous write port, one asynchronous read port.
module mdio_regfile
    import mdio_pkg::*;
#(
    parameter logic [DATA_W-1:0] REG_RESET = 16'h0000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= REG_RESET;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mdio_responder.sv
// MDIO management slave: decodes Clause-22 frames sampled on MDC rises, serves reads
// from the register file and commits writes.
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PHY_ADDR  = 5'd1,
    parameter logic [DATA_W-1:0] REG_RESET = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MDC,
    input  logic              MDIO_OUT,
    input  logic              MDIO_OE,
    output logic              MDIO_IN,
    output logic              MDIO_IN_OE,
    output logic              REG_WE,
    output logic [ADDR_W-1:0] REG_ADDR,
    output logic [DATA_W-1:0] REG_WDATA,
    output logic              RD_DONE,
    output logic              FRAME_ERR
);

    logic              mdc_q;
    logic [2:0]        state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mdio_in_q, mdio_in_d;
    logic              in_oe_q, in_oe_d;
    logic              we_q, we_d;
    logic              rd_done_q, rd_done_d;
    logic              ferr_q, ferr_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;

    logic              rise;
    logic [11:0]       hdr;
    logic [OP_W-1:0]   hdr_op;
    logic [ADDR_W-1:0] hdr_phy;
    logic [ADDR_W-1:0] hdr_reg;
    logic [DATA_W-1:0] shift_in;
    logic              rf_we;
    logic [DATA_W-1:0] rf_rdata;

    assign rise     = ~mdc_q & MDC;
    // Bits 2..13 of the frame, valid on the rise of bit 13.
    assign hdr      = {sr_q[10:0], MDIO_OUT};
    assign hdr_op   = hdr[11:10];
    assign hdr_phy  = hdr[9:5];
    assign hdr_reg  = hdr[4:0];
    assign shift_in = {sr_q[DATA_W-2:0], MDIO_OUT};

    mdio_regfile #(
        .REG_RESET(REG_RESET)
    ) u_regfile (
        .clk_i  (clk),
        .rst_ni (rst),
        .we_i   (rf_we),
        .waddr_i(addr_q),
        .wdata_i(shift_in),
        .raddr_i(hdr_reg),
        .rdata_o(rf_rdata)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        addr_d      = addr_q;
        mdio_in_d   = mdio_in_q;
        in_oe_d     = in_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        we_d        = 1'b0;
        rd_done_d   = 1'b0;
        ferr_d      = 1'b0;
        rf_we       = 1'b0;

        if (rise) begin
            case (state_q)
                IDLE: begin
                    if (MDIO_OE && MDIO_OUT == ST_CODE[1]) begin
                        bit_cnt_d = ST_LAST;
                        state_d   = HDR;
                    end
                end
                HDR: begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    sr_d      = shift_in;
                    if (!MDIO_OE) begin
                        ferr_d  = 1'b1;
                        state_d = IDLE;
                    end else if (bit_cnt_q == ST_LAST && MDIO_OUT != ST_CODE[0]) begin
                        ferr_d  = 1'b1;
                        state_d = IDLE;
                    end else if (bit_cnt_q == HDR_LAST) begin
                        addr_d = hdr_reg;
                        if (hdr_op != OP_READ && hdr_op != OP_WRITE) begin
                            ferr_d  = 1'b1;
                            state_d = SKIP;
                        end else if (hdr_phy != PHY_ADDR) begin
                            state_d = SKIP;
                        end else if (hdr_op == OP_READ) begin
                            sr_d       = rf_rdata;
                            reg_addr_d = hdr_reg;
                            state_d    = RTA;
                        end else begin
                            state_d = WTA;
                        end
                    end
                end
                RTA: begin
                    // Drive the turnaround zero; data bits follow from RDATA.
                    in_oe_d   = 1'b1;
                    mdio_in_d = 1'b0;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    state_d   = RDATA;
                end
                RDATA: begin
                    if (bit_cnt_q == FRAME_LAST) begin
                        in_oe_d   = 1'b0;
                        mdio_in_d = 1'b0;
                        rd_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        mdio_in_d = sr_q[DATA_W-1];
                        sr_d      = {sr_q[DATA_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                WTA: begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (!MDIO_OE) begin
                        ferr_d  = 1'b1;
                        state_d = IDLE;
                    end else if ((bit_cnt_q == TA_POS && MDIO_OUT != TA_WR[1]) ||
                                 (bit_cnt_q == TA_LAST && MDIO_OUT != TA_WR[0])) begin
                        ferr_d  = 1'b1;
                        state_d = SKIP;
                    end else if (bit_cnt_q == TA_LAST) begin
                        state_d = WDATA;
                    end
                end
                WDATA: begin
                    if (!MDIO_OE) begin
                        ferr_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        sr_d      = shift_in;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == FRAME_LAST) begin
                            rf_we       = 1'b1;
                            we_d        = 1'b1;
                            reg_addr_d  = addr_q;
                            reg_wdata_d = shift_in;
                            state_d     = IDLE;
                        end
                    end
                end
                SKIP: begin
                    if (bit_cnt_q == FRAME_LAST) begin
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_d == IDLE) begin
            bit_cnt_d = ST_POS;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdc_q       <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            addr_q      <= '0;
            mdio_in_q   <= 1'b0;
            in_oe_q     <= 1'b0;
            we_q        <= 1'b0;
            rd_done_q   <= 1'b0;
            ferr_q      <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
        end else begin
            mdc_q       <= MDC;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            addr_q      <= addr_d;
            mdio_in_q   <= mdio_in_d;
            in_oe_q     <= in_oe_d;
            we_q        <= we_d;
            rd_done_q   <= rd_done_d;
            ferr_q      <= ferr_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    assign MDIO_IN    = mdio_in_q;
    assign MDIO_IN_OE = in_oe_q;
    assign REG_WE     = we_q;
    assign RD_DONE    = rd_done_q;
    assign FRAME_ERR  = ferr_q;
    assign REG_ADDR   = reg_addr_q;
    assign REG_WDATA  = reg_wdata_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Randomised frame-level bench for mdio_responder against a register-file model.
module tb_mdio_responder;

    localparam logic [4:0] PhyAddr = 5'd1;

    logic        clk;
    logic        rst;
    logic        MDC;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic        MDIO_IN;
    logic        MDIO_IN_OE;
    logic        REG_WE;
    logic [4:0]  REG_ADDR;
    logic [15:0] REG_WDATA;
    logic        RD_DONE;
    logic        FRAME_ERR;

    int n_total = 0;
    int n_bad   = 0;
    int we_cnt  = 0;
    int rd_cnt  = 0;
    int err_cnt = 0;

    logic [15:0] model_regs [32];
    logic [4:0]  model_addr;
    logic [15:0] model_wdata;

    mdio_responder #(
        .PHY_ADDR (PhyAddr),
        .REG_RESET(16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MDC       (MDC),
        .MDIO_OUT  (MDIO_OUT),
        .MDIO_OE   (MDIO_OE),
        .MDIO_IN   (MDIO_IN),
        .MDIO_IN_OE(MDIO_IN_OE),
        .REG_WE    (REG_WE),
        .REG_ADDR  (REG_ADDR),
        .REG_WDATA (REG_WDATA),
        .RD_DONE   (RD_DONE),
        .FRAME_ERR (FRAME_ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-clk pulses are counted on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (REG_WE)    we_cnt++;
        if (RD_DONE)   rd_cnt++;
        if (FRAME_ERR) err_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = 16'h0000;
        model_addr  = 5'd0;
        model_wdata = 16'h0000;
    endtask

    // One MDC period of 4 clks; returns on the falling edge after the rise was seen.
    task automatic mdc_bit(input logic b, input logic oe);
        @(negedge clk);
        MDC      = 1'b0;
        MDIO_OUT = b;
        MDIO_OE  = oe;
        @(negedge clk);
        @(negedge clk);
        MDC = 1'b1;
        @(negedge clk);
    endtask

    task automatic preamble(input int n);
        for (int i = 0; i < n; i++) mdc_bit(1'b1, 1'b1);
    endtask

    task automatic run_frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                             input logic [1:0] ta, input logic [15:0] wd,
                             input int drop_at, input int rst_at);
        logic [31:0] fr;
        logic [31:0] oe_seen;
        logic [31:0] oe_exp;
        logic [16:0] rd_seen;
        logic [15:0] exp_rd;
        logic        drive;
        bit          is_rd, is_wr, match, bad_op, bad_ta, exp_err, exp_wr, exp_rdd;
        int          we0, rd0, err0;

        fr      = {2'b01, op, phy, ra, ta, wd};
        is_rd   = (op == 2'b10);
        is_wr   = (op == 2'b01);
        bad_op  = !is_rd && !is_wr;
        match   = (phy == PhyAddr);
        bad_ta  = is_wr && match && (ta != 2'b10);
        exp_rd  = model_regs[ra];
        exp_rdd = is_rd && match;
        if (drop_at >= 1 && drop_at <= 13) begin
            exp_err = 1'b1;
            exp_wr  = 1'b0;
            exp_rdd = 1'b0;
        end else begin
            exp_err = bad_op || bad_ta || (drop_at >= 14 && is_wr && match && !bad_ta);
            exp_wr  = is_wr && match && !bad_ta && (drop_at < 0);
        end
        for (int i = 0; i < 32; i++) oe_exp[i] = exp_rdd && (i >= 14) && (i <= 30);

        we0     = we_cnt;
        rd0     = rd_cnt;
        err0    = err_cnt;
        oe_seen = '0;
        rd_seen = '0;

        for (int i = 0; i < 32; i++) begin
            drive = !(is_rd && i >= 14) && !(drop_at >= 0 && i >= drop_at);
            mdc_bit(fr[31-i], drive);
            oe_seen[i] = MDIO_IN_OE;
            if (i >= 14 && i <= 30) rd_seen[30-i] = MDIO_IN;
            if (i == rst_at) begin
                rst = 1'b0;
                MDC = 1'b0;
                #1;
                check_eq("rst_in_oe", {31'd0, MDIO_IN_OE}, 32'd0);
                check_eq("rst_in", {31'd0, MDIO_IN}, 32'd0);
                check_eq("rst_reg_addr", {27'd0, REG_ADDR}, 32'd0);
                check_eq("rst_wdata", {16'd0, REG_WDATA}, 32'd0);
                model_reset();
                repeat (3) @(negedge clk);
                rst = 1'b1;
                return;
            end
        end
        @(negedge clk);

        check_eq("we_pulses", we_cnt - we0, {31'd0, exp_wr});
        check_eq("rd_pulses", rd_cnt - rd0, {31'd0, exp_rdd});
        check_eq("err_pulses", err_cnt - err0, {31'd0, exp_err});
        check_eq("in_oe_window", oe_seen, oe_exp);
        if (exp_rdd) begin
            check_eq("rd_data", {15'd0, rd_seen}, {16'd0, 1'b0, exp_rd});
            model_addr = ra;
        end
        if (exp_wr) begin
            model_regs[ra] = wd;
            model_addr     = ra;
            model_wdata    = wd;
        end
        check_eq("reg_addr", {27'd0, REG_ADDR}, {27'd0, model_addr});
        check_eq("reg_wdata", {16'd0, REG_WDATA}, {16'd0, model_wdata});
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [1:0]  r_ta;
        logic [4:0]  r_phy;
        logic [4:0]  r_ra;
        logic [15:0] r_wd;
        int          sel;

        rst      = 1'b0;
        MDC      = 1'b0;
        MDIO_OUT = 1'b1;
        MDIO_OE  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("reset_in_oe", {31'd0, MDIO_IN_OE}, 32'd0);
        check_eq("reset_we", {31'd0, REG_WE}, 32'd0);
        check_eq("reset_rd_done", {31'd0, RD_DONE}, 32'd0);
        check_eq("reset_ferr", {31'd0, FRAME_ERR}, 32'd0);
        check_eq("reset_reg_addr", {27'd0, REG_ADDR}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        preamble(4);
        run_frame(2'b01, PhyAddr, 5'd5, 2'b10, 16'hBEEF, -1, -1);
        run_frame(2'b10, PhyAddr, 5'd5, 2'b10, 16'h0000, -1, -1);
        preamble(2);
        run_frame(2'b01, 5'd2, 5'd5, 2'b10, 16'h1234, -1, -1);
        run_frame(2'b10, PhyAddr, 5'd5, 2'b10, 16'h0000, -1, -1);
        run_frame(2'b01, PhyAddr, 5'd5, 2'b11, 16'h5555, -1, -1);
        run_frame(2'b00, PhyAddr, 5'd5, 2'b10, 16'h6666, -1, -1);
        run_frame(2'b01, PhyAddr, 5'd7, 2'b10, 16'hA5C3, -1, -1);
        run_frame(2'b10, PhyAddr, 5'd7, 2'b10, 16'h0000, -1, -1);
        run_frame(2'b01, PhyAddr, 5'd5, 2'b10, 16'hCAFE, 20, -1);
        preamble(2);
        run_frame(2'b10, PhyAddr, 5'd5, 2'b10, 16'h0000, -1, 22);
        preamble(3);
        run_frame(2'b10, PhyAddr, 5'd5, 2'b10, 16'h0000, -1, -1);
        run_frame(2'b10, PhyAddr, 5'd7, 2'b10, 16'h0000, -1, -1);

        for (int n = 0; n < 48; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 3)      r_op = 2'b01;
            else if (sel <= 7) r_op = 2'b10;
            else if (sel == 8) r_op = 2'b00;
            else               r_op = 2'b11;
            r_phy = ($urandom_range(0, 3) == 0) ? 5'($urandom) : PhyAddr;
            r_ra  = 5'($urandom_range(0, 7));
            r_ta  = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b10;
            r_wd  = 16'($urandom);
            preamble(int'($urandom_range(0, 2)));
            run_frame(r_op, r_phy, r_ra, r_ta, r_wd, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
